// File: rtl/cycle_time_display.sv
// cycle_time_display: picks the live or frozen cycle count, converts it to
// seconds with a serial restoring divider, converts the seconds to four BCD
// digits with a serial double-dabble, and scans them onto a 4-digit
// multiplexed 7-segment display (all display signals active-low).
//
// Optional build macro CYCLE_DISP_TENTHS_EN: divide by CLK_HZ/10 so the
// quotient is tenths of a second, and light the decimal point on the tens
// digit (SSS.s). Without it the display shows whole seconds and dp stays off.
//
// Conversion sequence (free-running, 48 cycles):
//   IDLE (1) -> DIV (32) -> BCD (14) -> LOAD (1) -> IDLE
module cycle_time_display #(
    parameter int CLK_HZ   = 100000000,
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tim,
    input  logic [31:0] tim_reg,
    input  logic        hold,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic [15:0] bcd,
    output logic        valid,
    output logic        ovf
);

`ifdef CYCLE_DISP_TENTHS_EN
    localparam logic [31:0] DIVISOR = 32'(CLK_HZ / 10);
`else
    localparam logic [31:0] DIVISOR = 32'(CLK_HZ);
`endif

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [4:0] DIV_LAST = 5'd31;
    localparam logic [4:0] BCD_LAST = 5'd13;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_BCD,
        S_LOAD
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [4:0]        step_cnt;

    // Divider / converter working registers (data path, no reset needed)
    logic [31:0]       quo;
    logic [31:0]       rem;
    logic [29:0]       work;
    logic              ovf_work;

    logic [32:0]       rem_sh;
    logic              rem_ge;
    logic [14:0]       clamp_res;

    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        idx;
    logic [3:0]        digit;

    // Clamp the quotient to 4 decimal digits; returns {clamped, value}.
    function automatic logic [14:0] clamp_q(input logic [31:0] q);
        if (q > 32'd9999) begin
            return {1'b1, 14'd9999};
        end
        return {1'b0, q[13:0]};
    endfunction

    // One double-dabble step on {bcd[15:0], binary[13:0]}:
    // add 3 to every BCD nibble that is 5 or more, then shift left one bit.
    function automatic logic [29:0] dabble_step(input logic [29:0] w);
        logic [29:0] t;
        t = w;
        for (int n = 0; n < 4; n++) begin
            if (t[14 + 4*n +: 4] >= 4'd5) begin
                t[14 + 4*n +: 4] = t[14 + 4*n +: 4] + 4'd3;
            end
        end
        return 30'(t << 1);
    endfunction

    // 7-segment pattern {g,f,e,d,c,b,a}, active-low; non-decimal is blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencer next-state: fixed-length phases counted by step_cnt
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_DIV;
            S_DIV:  if (step_cnt == DIV_LAST) state_nxt = S_BCD;
            S_BCD:  if (step_cnt == BCD_LAST) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Step counter restarts at zero on every phase change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (state_nxt != state) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + 5'd1;
        end
    end

    // Restoring-division trial subtraction and quotient clamp
    always_comb begin
        rem_sh    = {rem, quo[31]};
        rem_ge    = (rem_sh >= {1'b0, DIVISOR});
        clamp_res = clamp_q(quo);
    end

    // Operand capture, division and BCD conversion working registers
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                quo <= hold ? tim_reg : tim;
                rem <= '0;
            end
            S_DIV: begin
                if (rem_ge) begin
                    rem <= 32'(rem_sh - {1'b0, DIVISOR});
                end else begin
                    rem <= rem_sh[31:0];
                end
                quo <= {quo[30:0], rem_ge};
            end
            S_BCD: begin
                if (step_cnt == '0) begin
                    work     <= dabble_step({16'h0000, clamp_res[13:0]});
                    ovf_work <= clamp_res[14];
                end else begin
                    work <= dabble_step(work);
                end
            end
            default: begin
            end
        endcase
    end

    // ---- stage boundary: conversion result published to outputs ----
    // Publish result and strobe valid in the cycle the result lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd   <= '0;
            ovf   <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= (state == S_LOAD);
            if (state == S_LOAD) begin
                bcd <= work[29:14];
                ovf <= ovf_work;
            end
        end
    end

    // Scan timer: each digit is enabled for SCAN_DIV cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Select the BCD nibble for the digit being scanned
    always_comb begin
        digit = bcd[3:0];
        case (idx)
            2'd0: digit = bcd[3:0];
            2'd1: digit = bcd[7:4];
            2'd2: digit = bcd[11:8];
            2'd3: digit = bcd[15:12];
            default: digit = bcd[3:0];
        endcase
    end

    // ---- stage boundary: registered display drive ----
    // Register anode, segment and decimal-point drive for the current digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_decode(digit);
`ifdef CYCLE_DISP_TENTHS_EN
            dp  <= (idx != 2'd1);
`else
            dp  <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_cycle_time_display.sv
// Self-checking bench for cycle_time_display (CLK_HZ=100, SCAN_DIV=4).
// Expected conversions are queued at each operand-sampling edge and popped
// when valid pulses. Honours CYCLE_DISP_TENTHS_EN when defined.
module tb_cycle_time_display;

    localparam int CLK_HZ   = 100;
    localparam int SCAN_DIV = 4;
    localparam int PERIOD   = 48;

`ifdef CYCLE_DISP_TENTHS_EN
    localparam int unsigned DIVS = CLK_HZ / 10;
    localparam bit TENTHS = 1'b1;
`else
    localparam int unsigned DIVS = CLK_HZ;
    localparam bit TENTHS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] tim;
    logic [31:0] tim_reg;
    logic        hold;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic [15:0] bcd;
    logic        valid;
    logic        ovf;

    int          n_checks;
    int          n_fail;
    int unsigned edge_cnt;
    logic [16:0] exp_q[$];

    cycle_time_display #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tim    (tim),
        .tim_reg(tim_reg),
        .hold   (hold),
        .seg    (seg),
        .an     (an),
        .dp     (dp),
        .bcd    (bcd),
        .valid  (valid),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference conversion: {ovf, thousands, hundreds, tens, ones}
    function automatic logic [16:0] model(input logic [31:0] x);
        int unsigned q;
        logic        o;
        q = x / DIVS;
        o = (q > 9999);
        if (o) q = 9999;
        return {o, 4'(q / 1000), 4'((q / 100) % 10), 4'((q / 10) % 10), 4'(q % 10)};
    endfunction

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Scoreboard: push at sampling edges, pop/compare on valid
    always @(posedge clk) begin
        logic [16:0] e;
        logic        exp_valid;
        if (rst) begin
            edge_cnt = 0;
            exp_q.delete();
        end else begin
            edge_cnt++;
            if ((edge_cnt - 1) % PERIOD == 0) exp_q.push_back(model(hold ? tim_reg : tim));
            #2;
            exp_valid = (edge_cnt % PERIOD == 0);
            if (valid || exp_valid) begin
                check_val("valid_timing", 32'(valid), 32'(exp_valid));
                if (valid) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_val("bcd", 32'(bcd), 32'(e[15:0]));
                        check_val("ovf", 32'(ovf), 32'(e[16]));
                    end else begin
                        check_val("sb_empty", 32'(1), 32'(0));
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_seg"},   32'(seg),   32'(7'h7F));
        check_val({tag, "_an"},    32'(an),    32'(4'hF));
        check_val({tag, "_dp"},    32'(dp),    32'(1));
        check_val({tag, "_bcd"},   32'(bcd),   32'(0));
        check_val({tag, "_valid"}, 32'(valid), 32'(0));
        check_val({tag, "_ovf"},   32'(ovf),   32'(0));
    endtask

    initial begin
        logic [16:0] e_scan;
        logic [3:0]  prev_an;
        logic        found;
        logic [3:0]  dgt;
        logic [3:0]  an_exp;

        n_checks = 0;
        n_fail   = 0;
        edge_cnt = 0;
        rst      = 1'b1;
        hold     = 1'b0;
        tim      = 32'd12345;
        tim_reg  = 32'd0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #3;
        check_val("first_an",  32'(an),  32'(4'b1110));
        check_val("first_seg", 32'(seg), 32'(7'b1000000));
        check_val("first_dp",  32'(dp),  32'(1));

        // Steady live count over two conversions
        repeat (100) @(negedge clk);

        // Scan order for the steady value
        e_scan  = model(32'd12345);
        found   = 1'b0;
        prev_an = an;
        for (int i = 0; i < 24 && !found; i++) begin
            @(posedge clk);
            #3;
            if (an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
            else prev_an = an;
        end
        check_val("scan_sync", 32'(found), 32'(1));
        if (found) begin
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < SCAN_DIV; c++) begin
                    dgt    = e_scan[4*d +: 4];
                    an_exp = ~(4'b0001 << d);
                    check_val("scan_an",  32'(an),  32'(an_exp));
                    check_val("scan_seg", 32'(seg), 32'(seg_ref(dgt)));
                    check_val("scan_dp",  32'(dp),  32'((TENTHS && d == 1) ? 1'b0 : 1'b1));
                    @(posedge clk);
                    #3;
                end
            end
        end

        // Hold selects the frozen count while the live count keeps moving
        @(negedge clk);
        hold    = 1'b1;
        tim_reg = 32'd500;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            tim = tim + 32'd1;
        end

        // Overflow clamp, then recovery (ovf not sticky)
        hold = 1'b0;
        tim  = 32'hFFFF_FFFF;
        repeat (110) @(negedge clk);
        tim = 32'd199;
        repeat (110) @(negedge clk);

        // Reset 10 cycles into DIV
        found = 1'b0;
        for (int i = 0; i < 2 * PERIOD && !found; i++) begin
            @(negedge clk);
            if (edge_cnt % PERIOD == 11) found = 1'b1;
        end
        check_val("div_sync", 32'(found), 32'(1));
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        tim = 32'd12345;
        rst = 1'b0;
        repeat (110) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
